// File: rtl/pcieifc_fifo2axis.sv
// Drains a first-word-fall-through FIFO into an AXI-Stream master through a 2-entry skid buffer,
// truncating packets longer than MAX_BEATS (forced tlast) and discarding their remaining beats.
module pcieifc_fifo2axis #(
  parameter int DSIZE     = 256,
  parameter int KSIZE     = 8,
  parameter int MAX_BEATS = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   fifo_empty,
  input  logic [DSIZE+KSIZE:0]   fifo_dout,
  output logic                   fifo_ren,
  output logic                   m_axis_tvalid,
  output logic [DSIZE-1:0]       m_axis_tdata,
  output logic [KSIZE-1:0]       m_axis_tkeep,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [15:0]            pkt_cnt,
  output logic                   err_oversize,
  output logic [7:0]             err_cnt
);

  typedef enum logic {PASS, DROP} state_t;

  state_t            state, state_nxt;
  logic [15:0]       beat_cnt, beat_nxt;
  logic              skid_vld;
  logic [DSIZE-1:0]  skid_data;
  logic [KSIZE-1:0]  skid_keep;
  logic              skid_last;
  logic              accept;
  logic [1:0]        occ_after;
  logic              in_last;
  logic [KSIZE-1:0]  in_keep;
  logic [DSIZE-1:0]  in_data;
  logic              push;
  logic              trunc;
  logic              push_last;

  assign in_last   = fifo_dout[DSIZE+KSIZE];
  assign in_keep   = fifo_dout[DSIZE +: KSIZE];
  assign in_data   = fifo_dout[DSIZE-1:0];
  assign accept    = m_axis_tvalid & m_axis_tready;
  // Occupancy after this cycle's downstream accept; a pop is allowed if it leaves room.
  assign occ_after = {1'b0, m_axis_tvalid} + {1'b0, skid_vld} - {1'b0, accept};

  always_comb begin
    fifo_ren = 1'b0;
    if (rst_n && !clr && !fifo_empty) begin
      fifo_ren = (state == DROP) || (occ_after < 2'd2);
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    push      = 1'b0;
    trunc     = 1'b0;
    case (state)
      PASS: begin
        if (fifo_ren) begin
          push  = 1'b1;
          trunc = !in_last && (beat_cnt == 16'(MAX_BEATS - 1));
          if (in_last || trunc) begin
            beat_nxt = 16'd0;
          end else begin
            beat_nxt = beat_cnt + 16'd1;
          end
          if (trunc) begin
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (fifo_ren && in_last) begin
          state_nxt = PASS;
        end
      end
      default: state_nxt = PASS;
    endcase
  end

  assign push_last    = in_last | trunc;
  assign err_oversize = trunc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PASS;
      beat_cnt      <= 16'd0;
      pkt_cnt       <= 16'd0;
      err_cnt       <= 8'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      skid_vld      <= 1'b0;
      skid_data     <= '0;
      skid_keep     <= '0;
      skid_last     <= 1'b0;
    end else if (clr) begin
      state         <= PASS;
      beat_cnt      <= 16'd0;
      pkt_cnt       <= 16'd0;
      err_cnt       <= 8'd0;
      m_axis_tvalid <= 1'b0;
      skid_vld      <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
      if (accept && m_axis_tlast) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (trunc && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      // Head is held while stalled; new beats go to the skid slot.
      if (m_axis_tvalid && !accept) begin
        if (!skid_vld && push) begin
          skid_vld  <= 1'b1;
          skid_data <= in_data;
          skid_keep <= in_keep;
          skid_last <= push_last;
        end
      end else if (skid_vld) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= skid_data;
        m_axis_tkeep  <= skid_keep;
        m_axis_tlast  <= skid_last;
        skid_vld      <= push;
        if (push) begin
          skid_data <= in_data;
          skid_keep <= in_keep;
          skid_last <= push_last;
        end
      end else begin
        m_axis_tvalid <= push;
        if (push) begin
          m_axis_tdata <= in_data;
          m_axis_tkeep <= in_keep;
          m_axis_tlast <= push_last;
        end
      end
    end
  end

endmodule
